// File: rtl/drp_reconf_master_if.sv
// DRP port bundle between the reconfiguration master and the PLL.
interface drp_reconf_master_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_data;  // "do" is a reserved word
  logic        drdy;

  modport master (output daddr, den, dwe, di, input do_data, drdy);
  modport slave  (input daddr, den, dwe, di, output do_data, drdy);
endinterface

// File: rtl/drp_reconf_master.sv
// DRP read-modify-write sequencer that reprograms a PLL from a table and waits for lock.
// Optional watchdog: define DRP_TIMEOUT_EN.
module drp_reconf_master #(
  parameter int NUM_ENTRIES     = 23,
  parameter int IDX_W           = 7,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     tbl_idx,
  input  logic [6:0]           tbl_addr,
  input  logic [15:0]          tbl_mask,
  input  logic [15:0]          tbl_data,
  drp_reconf_master_if.master  drp,
  output logic                 pll_rst,
  input  logic                 locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_READ, S_WAIT_R, S_WRITE, S_WAIT_W, S_RELEASE, S_WAIT_LOCK, S_DONE
  } state_t;

  localparam int               HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [6:0]        daddr_q;
  logic [15:0]       di_q;
  logic              timeout;

`ifdef DRP_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;
  logic            wait_met;

  assign in_wait  = (state == S_WAIT_R) || (state == S_WAIT_W) || (state == S_WAIT_LOCK);
  assign wait_met = ((state == S_WAIT_R || state == S_WAIT_W) && drp.drdy) ||
                    (state == S_WAIT_LOCK && locked);
  // A response arriving on the last allowed cycle still counts as success.
  assign timeout  = in_wait && !wait_met && (wd_cnt == WD_LAST);

  always_ff @(posedge dclk) begin
    if (rst || state_nxt != state) wd_cnt <= '0;
    else if (in_wait)              wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge dclk) begin
    if (rst)                          error <= 1'b0;
    else if (state == S_IDLE && start) error <= 1'b0;
    else if (timeout)                 error <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge dclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pll_rst   = 1'b0;
    drp.den   = 1'b0;
    drp.dwe   = 1'b0;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_RST_HOLD;
      S_RST_HOLD: begin
        busy    = 1'b1;
        pll_rst = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        pll_rst   = 1'b1;
        drp.den   = 1'b1;
        state_nxt = S_WAIT_R;
      end
      S_WAIT_R: begin
        busy    = 1'b1;
        pll_rst = 1'b1;
        if (drp.drdy)     state_nxt = S_WRITE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        pll_rst   = 1'b1;
        drp.den   = 1'b1;
        drp.dwe   = 1'b1;
        state_nxt = S_WAIT_W;
      end
      S_WAIT_W: begin
        busy    = 1'b1;
        pll_rst = 1'b1;
        if (drp.drdy)     state_nxt = (tbl_idx == IDX_LAST) ? S_RELEASE : S_READ;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_RELEASE: begin
        busy      = 1'b1;
        state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        busy = 1'b1;
        if (locked)       state_nxt = S_DONE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The table address is combinational on tbl_idx, so it is forwarded during READ
  // and captured for the rest of the entry.
  assign drp.daddr = (state == S_READ) ? tbl_addr : daddr_q;
  assign drp.di    = di_q;

  always_ff @(posedge dclk) begin
    if (rst) begin
      hold_cnt <= '0;
      tbl_idx  <= '0;
      daddr_q  <= '0;
      di_q     <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        hold_cnt <= '0;
        tbl_idx  <= '0;
      end
      if (state == S_RST_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == S_READ)     daddr_q  <= tbl_addr;
      if (state == S_WAIT_R && drp.drdy)
        di_q <= (drp.do_data & tbl_mask) | (tbl_data & ~tbl_mask);
      if (state == S_WAIT_W && drp.drdy && tbl_idx != IDX_LAST)
        tbl_idx <= tbl_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_drp_reconf_master.sv
// Self-checking bench for drp_reconf_master: DRP/PLL responder models plus a table-level reference model.
module tb_drp_reconf_master;
  localparam int N    = 3;
  localparam int IW   = 2;
  localparam int HOLD = 4;
  localparam int TMO  = 20;

  logic dclk  = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  bit   locked;
  logic busy, done, error, pll_rst;
  logic [IW-1:0] tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask, tbl_data;

  logic [6:0]  t_addr [4];
  logic [15:0] t_mask [4];
  logic [15:0] t_data [4];

  drp_reconf_master_if drp ();

  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_mask = t_mask[tbl_idx];
  assign tbl_data = t_data[tbl_idx];

  always #5 dclk = ~dclk;

  drp_reconf_master #(
    .NUM_ENTRIES(N), .IDX_W(IW), .RST_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .dclk(dclk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
    .drp(drp), .pll_rst(pll_rst), .locked(locked)
  );

  // ---------------- DRP responder (register file of the PLL) ----------------
  logic [15:0] mem     [128];
  logic [15:0] mem_img [128];
  int  load_req = 0, load_ack = 0;
  int  resp_delay = 1;
  bit  resp_off = 0, stray_en = 0;
  bit  pend = 0;
  int  pend_cnt;
  logic [6:0]  pend_addr;
  bit          pend_we;
  logic [15:0] pend_di;
  int  resp_viol = 0;
  logic [6:0]  log_addr[$];
  bit          log_we[$];
  logic [15:0] log_data[$];
  int          log_idx[$];

  always @(posedge dclk) begin
    drp.drdy <= 1'b0;
    if (load_req != load_ack) begin
      foreach (mem[i]) mem[i] = mem_img[i];
      load_ack = load_req;
    end
    if (rst) pend = 0;
    else begin
      if (drp.den) begin
        if (pend) resp_viol++;
        pend = 1; pend_cnt = resp_delay;
        pend_addr = drp.daddr; pend_we = drp.dwe; pend_di = drp.di;
        log_addr.push_back(drp.daddr); log_we.push_back(drp.dwe);
        log_data.push_back(drp.di);    log_idx.push_back(int'(tbl_idx));
      end
      if (pend && !resp_off) begin
        if (pend_cnt <= 1) begin
          drp.drdy <= 1'b1;
          if (pend_we) mem[pend_addr] = pend_di;
          else drp.do_data <= mem[pend_addr];
          pend = 0;
        end else pend_cnt--;
      end else if (!pend && stray_en && $urandom_range(0, 3) == 0) begin
        drp.drdy    <= 1'b1;
        drp.do_data <= 16'($urandom);
      end
    end
  end

  // ---------------- PLL lock model ----------------
  int lock_delay = 1;
  bit lock_never = 0;
  int lcnt = 0;
  always @(posedge dclk) begin
    if (pll_rst) begin
      lcnt = 0; locked <= 1'b0;
    end else if (!lock_never && !locked) begin
      lcnt++;
      if (lcnt >= lock_delay) locked <= 1'b1;
    end
  end

  // ---------------- protocol monitor ----------------
  int mon_viol = 0, done_total = 0, phase = 0;
  logic [6:0] ph_addr;
  always @(negedge dclk) begin
    if (rst || !busy) phase = 0;
    if (!rst) begin
      if (drp.drdy) begin
        if (phase == 1) phase = 2;
        else if (phase == 3) phase = 0;
      end
      if (drp.den) begin
        if (!pll_rst) mon_viol++;
        if (!drp.dwe) begin
          if (phase != 0) mon_viol++;
          phase = 1; ph_addr = drp.daddr;
        end else begin
          if (phase != 2 || drp.daddr !== ph_addr) mon_viol++;
          phase = 3;
        end
      end else if (drp.dwe) mon_viol++;
      if (phase != 0 && drp.daddr !== ph_addr) mon_viol++;
      if (done) done_total++;
    end
  end

  // ---------------- reference model ----------------
  logic [6:0]  exp_addr[$];
  bit          exp_we[$];
  logic [15:0] exp_data[$];
  int log_base = 0;

  task automatic build_model();
    logic [15:0] m [128];
    logic [15:0] v;
    foreach (mem[i]) m[i] = mem[i];
    exp_addr.delete(); exp_we.delete(); exp_data.delete();
    for (int e = 0; e < N; e++) begin
      v = (m[t_addr[e]] & t_mask[e]) | (t_data[e] & ~t_mask[e]);
      m[t_addr[e]] = v;
      exp_addr.push_back(t_addr[e]); exp_we.push_back(1'b0); exp_data.push_back(16'h0);
      exp_addr.push_back(t_addr[e]); exp_we.push_back(1'b1); exp_data.push_back(v);
    end
  endtask

  function automatic int log_mismatch();
    int b;
    b = log_base;
    if (log_addr.size() - b != exp_addr.size()) return -2;
    foreach (exp_addr[j])
      if (log_addr[b+j] !== exp_addr[j] || log_we[b+j] !== exp_we[j] || log_idx[b+j] != j / 2 ||
          (exp_we[j] && log_data[b+j] !== exp_data[j])) return j;
    return -1;
  endfunction

  function automatic int exp_lat(input int d, input int lk);
    return HOLD + N * (2 + 2 * d) + 2 + lk;
  endfunction

  task automatic load_mem_random(input bit all_ones);
    foreach (mem_img[i]) mem_img[i] = all_ones ? 16'hFFFF : 16'($urandom);
    load_req++;
    @(negedge dclk);
  endtask

  task automatic random_table();
    for (int e = 0; e < 4; e++) begin
      t_addr[e] = 7'($urandom_range(0, 7));
      t_mask[e] = 16'($urandom);
      t_data[e] = 16'($urandom);
    end
  endtask

  // ---------------- sequence driver ----------------
  int r_lat, r_err_k, r_pll_hi_k, r_pll_lo_k, r_busy_gap;
  int n_checks = 0, n_fail = 0;

  task automatic run_seq(input int budget, input int restart_k);
    int k;
    log_base = log_addr.size();
    r_lat = -1; r_err_k = -1; r_pll_hi_k = -1; r_pll_lo_k = -1; r_busy_gap = 0;
    @(negedge dclk); start = 1'b1;
    @(negedge dclk);
    k = 1;
    while (k <= budget) begin
      start = (k == restart_k);
      if (pll_rst && r_pll_hi_k < 0) r_pll_hi_k = k;
      if (!pll_rst && r_pll_hi_k >= 0 && r_pll_lo_k < 0) r_pll_lo_k = k;
      if (done)  begin r_lat = k;   break; end
      if (error) begin r_err_k = k; break; end
      if (!busy) r_busy_gap++;
      @(negedge dclk);
      k++;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge dclk);
    n_checks++;
    if ({busy, done, error, drp.den, drp.dwe, pll_rst} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, error, drp.den, drp.dwe, pll_rst});
    end
    n_checks++;
    if (tbl_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", tbl_idx); end
    n_checks++;
    if ({drp.daddr, drp.di} !== 23'b0) begin
      n_fail++; $display("FAIL reset_bus: daddr=%h di=%h expected 0", drp.daddr, drp.di);
    end
    rst = 1'b0;
    repeat (2) @(negedge dclk);
  endtask

  task automatic test_directed();
    int v0, m0, d0, mm;
    t_addr[0] = 7'h08; t_mask[0] = 16'hF000; t_data[0] = 16'h0123;
    t_addr[1] = 7'h09; t_mask[1] = 16'h00FF; t_data[1] = 16'hAB00;
    t_addr[2] = 7'h0A; t_mask[2] = 16'h0F0F; t_data[2] = 16'h5050;
    t_addr[3] = 7'h00; t_mask[3] = 16'h0000; t_data[3] = 16'h0000;
    resp_delay = 1; lock_delay = 3; stray_en = 0;
    load_mem_random(1'b1);
    build_model();
    v0 = resp_viol + mon_viol; d0 = done_total;
    run_seq(200, -1);
    n_checks++;
    if (r_lat != exp_lat(1, 3)) begin n_fail++; $display("FAIL dir_latency: got %0d expected %0d", r_lat, exp_lat(1, 3)); end
    n_checks++;
    if (r_pll_hi_k != 1 || r_pll_lo_k != HOLD + 4 * N + 1) begin
      n_fail++; $display("FAIL dir_pll_rst: high@%0d low@%0d expected 1/%0d", r_pll_hi_k, r_pll_lo_k, HOLD + 4 * N + 1);
    end
    n_checks++;
    if (r_busy_gap != 0) begin n_fail++; $display("FAIL dir_busy: %0d idle cycles expected 0", r_busy_gap); end
    n_checks++;
    if (log_addr[log_base+1] !== 7'h08 || log_data[log_base+1] !== 16'hF123) begin
      n_fail++; $display("FAIL dir_write0: got %h@%h expected f123@08", log_data[log_base+1], log_addr[log_base+1]);
    end
    n_checks++;
    if (log_addr[log_base+3] !== 7'h09 || log_data[log_base+3] !== 16'hABFF) begin
      n_fail++; $display("FAIL dir_write1: got %h@%h expected abff@09", log_data[log_base+3], log_addr[log_base+3]);
    end
    mm = log_mismatch();
    n_checks++;
    if (mm != -1) begin n_fail++; $display("FAIL dir_model: mismatch at %0d expected none", mm); end
    @(negedge dclk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_total - d0 != 1) begin
      n_fail++; $display("FAIL dir_done_pulse: done=%b busy=%b pulses=%0d expected 0/0/1", done, busy, done_total - d0);
    end
    n_checks++;
    if (resp_viol + mon_viol != v0) begin n_fail++; $display("FAIL dir_protocol: got %0d violations expected 0", resp_viol + mon_viol - v0); end
  endtask

  task automatic test_back_to_back_start();
    int d0, mm;
    random_table();
    resp_delay = 1; lock_delay = 2;
    build_model();
    d0 = done_total;
    run_seq(200, 6);
    repeat (10) @(negedge dclk);
    mm = log_mismatch();
    n_checks++;
    if (mm != -1) begin n_fail++; $display("FAIL restart_model: mismatch at %0d expected none", mm); end
    n_checks++;
    if (r_lat != exp_lat(1, 2)) begin n_fail++; $display("FAIL restart_latency: got %0d expected %0d", r_lat, exp_lat(1, 2)); end
    n_checks++;
    if (done_total - d0 != 1) begin n_fail++; $display("FAIL restart_done: got %0d pulses expected 1", done_total - d0); end
  endtask

  task automatic test_slow_drdy();
    int v0, mm;
    random_table();
    load_mem_random(1'b0);
    resp_delay = 5; lock_delay = 1;
    build_model();
    v0 = resp_viol + mon_viol;
    run_seq(300, -1);
    mm = log_mismatch();
    n_checks++;
    if (mm != -1) begin n_fail++; $display("FAIL slow_model: mismatch at %0d expected none", mm); end
    n_checks++;
    if (r_lat != exp_lat(5, 1)) begin n_fail++; $display("FAIL slow_latency: got %0d expected %0d", r_lat, exp_lat(5, 1)); end
    n_checks++;
    if (resp_viol + mon_viol != v0) begin n_fail++; $display("FAIL slow_protocol: got %0d violations expected 0", resp_viol + mon_viol - v0); end
  endtask

  task automatic test_random();
    int v0, mm, d, lk;
    stray_en = 1;
    for (int it = 0; it < 6; it++) begin
      random_table();
      if (it % 2 == 0) load_mem_random(1'b0);
      d = $urandom_range(1, 4); lk = $urandom_range(1, 6);
      resp_delay = d; lock_delay = lk;
      build_model();
      v0 = resp_viol + mon_viol;
      run_seq(300, -1);
      mm = log_mismatch();
      n_checks++;
      if (mm != -1) begin n_fail++; $display("FAIL rand%0d_model: mismatch at %0d expected none", it, mm); end
      n_checks++;
      if (r_lat != exp_lat(d, lk)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, r_lat, exp_lat(d, lk)); end
      n_checks++;
      if (resp_viol + mon_viol != v0) begin n_fail++; $display("FAIL rand%0d_protocol: got %0d violations expected 0", it, resp_viol + mon_viol - v0); end
      repeat (2) @(negedge dclk);
    end
    stray_en = 0;
  endtask

  task automatic test_rst_mid();
    bit seen;
    int n0, mm;
    random_table();
    resp_delay = 5; lock_delay = 1;
    @(negedge dclk); start = 1'b1;
    @(negedge dclk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (drp.den && drp.dwe) begin seen = 1; break; end
      @(negedge dclk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_write_seen: got 0 expected 1"); end
    @(negedge dclk);
    rst = 1'b1;
    @(negedge dclk);
    n_checks++;
    if ({drp.den, drp.dwe, pll_rst, busy, error} !== 5'b0 || tbl_idx !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: den/dwe/pll_rst/busy/error=%b idx=%0d expected 0", {drp.den, drp.dwe, pll_rst, busy, error}, tbl_idx);
    end
    rst = 1'b0;
    n0 = log_addr.size();
    repeat (10) @(negedge dclk);
    n_checks++;
    if (log_addr.size() != n0) begin n_fail++; $display("FAIL rstmid_no_den: got %0d new DEN expected 0", log_addr.size() - n0); end
    resp_delay = 1;
    build_model();
    run_seq(200, -1);
    mm = log_mismatch();
    n_checks++;
    if (mm != -1 || r_lat != exp_lat(1, 1)) begin
      n_fail++; $display("FAIL rstmid_rerun: mismatch=%0d latency=%0d expected -1/%0d", mm, r_lat, exp_lat(1, 1));
    end
  endtask

  task automatic test_timeout_lock();
    int d0;
    resp_delay = 1; lock_never = 1;
    d0 = done_total;
    run_seq(80, -1);
`ifdef DRP_TIMEOUT_EN
    n_checks++;
    if (r_err_k != HOLD + 4 * N + 2 + TMO) begin
      n_fail++; $display("FAIL lock_timeout_k: got %0d expected %0d", r_err_k, HOLD + 4 * N + 2 + TMO);
    end
    n_checks++;
    if (busy !== 1'b0 || pll_rst !== 1'b0 || done_total != d0) begin
      n_fail++; $display("FAIL lock_timeout_state: busy=%b pll_rst=%b dones=%0d expected 0/0/0", busy, pll_rst, done_total - d0);
    end
    lock_never = 0;
`else
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0 || r_lat != -1) begin
      n_fail++; $display("FAIL lock_wait: busy=%b error=%b lat=%0d expected 1/0/-1", busy, error, r_lat);
    end
    lock_never = 0;
    for (int k = 0; k < 20 && busy; k++) @(negedge dclk);
    n_checks++;
    if (busy !== 1'b0 || done_total - d0 != 1) begin
      n_fail++; $display("FAIL lock_late: busy=%b dones=%0d expected 0/1", busy, done_total - d0);
    end
`endif
    repeat (2) @(negedge dclk);
  endtask

  task automatic test_timeout_drdy();
    int mm;
    resp_delay = 1; resp_off = 1;
    run_seq(60, -1);
`ifdef DRP_TIMEOUT_EN
    n_checks++;
    if (r_err_k != HOLD + 2 + TMO || busy !== 1'b0) begin
      n_fail++; $display("FAIL drdy_timeout: err@%0d busy=%b expected %0d/0", r_err_k, busy, HOLD + 2 + TMO);
    end
    resp_off = 0;
    repeat (2) @(negedge dclk);
`else
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL drdy_wait: busy=%b error=%b expected 1/0", busy, error);
    end
    resp_off = 0;
    rst = 1'b1;
    @(negedge dclk);
    rst = 1'b0;
    @(negedge dclk);
`endif
    random_table();
    lock_delay = 2;
    build_model();
    run_seq(200, -1);
    mm = log_mismatch();
    n_checks++;
    if (r_err_k != -1 || error !== 1'b0) begin n_fail++; $display("FAIL drdy_error_clear: err@%0d error=%b expected -1/0", r_err_k, error); end
    n_checks++;
    if (mm != -1 || r_lat != exp_lat(1, 2)) begin
      n_fail++; $display("FAIL drdy_recover: mismatch=%0d latency=%0d expected -1/%0d", mm, r_lat, exp_lat(1, 2));
    end
  endtask

  initial begin
    foreach (t_addr[i]) begin t_addr[i] = '0; t_mask[i] = '0; t_data[i] = '0; end
    test_reset();
    test_directed();
    test_back_to_back_start();
    test_slow_drdy();
    test_random();
    test_rst_mid();
    test_timeout_lock();
    test_timeout_drdy();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global time limit");
  end
endmodule

// File: doc/drp_reconf_master.md
Name: drp_reconf_master

Overview:
- DRP initiator that reprograms the PLL model at run time over its DADDR/DEN/DWE/DI/DO/DRDY port.
- On START it:
  - holds the PLL in reset;
  - walks a table of {address, keep-mask, data} entries, doing a read-modify-write per entry;
  - releases the PLL reset and waits for LOCKED.
- Sits between user logic and the PLL's reconfiguration port and RST input.

Parameters:
- NUM_ENTRIES, 23, number of table entries processed per START (1..128).
- IDX_W, 7, width of TBL_IDX; must satisfy 2^IDX_W >= NUM_ENTRIES.
- RST_HOLD_CYCLES, 4, DCLK cycles PLL_RST is held high before the first DRP read (>=1).
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with DRP_TIMEOUT_EN.

Ports:
- DCLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- START  in  1  single-cycle request to begin a reconfiguration
- BUSY  out  1  high from the cycle after accepted START until DONE
- DONE  out  1  one-cycle pulse when the sequence completes with PLL locked
- ERROR  out  1  sticky watchdog flag, cleared by next accepted START or RST
- TBL_IDX  out  IDX_W  current table entry index
- TBL_ADDR  in  7  DRP address of entry TBL_IDX, valid combinationally
- TBL_MASK  in  16  keep-mask of entry; 1 = keep the read-back bit
- TBL_DATA  in  16  new bits of entry; used where mask = 0
- DADDR  out  7  DRP address to PLL
- DEN  out  1  DRP enable, one-cycle pulse per transaction
- DWE  out  1  DRP write enable, high only together with DEN on writes
- DI  out  16  DRP write data
- DO  in  16  DRP read data, valid when DRDY=1
- DRDY  in  1  DRP transaction complete
- PLL_RST  out  1  drives PLL RST
- LOCKED  in  1  PLL LOCKED

Behaviour:
Reset values (RST high at an edge sets all of these on that edge):
- BUSY=0, DONE=0, ERROR=0, TBL_IDX=0, DADDR=0, DEN=0, DWE=0, DI=0, PLL_RST=0.
- State goes to IDLE.
- RST mid-operation: abandon any outstanding DRP transaction; no further DEN.

States:
- IDLE:
  - START=1 → RST_HOLD; BUSY=1, PLL_RST=1, TBL_IDX=0, ERROR=0, hold counter cleared.
  - START while BUSY is ignored.
- RST_HOLD:
  - Count RST_HOLD_CYCLES cycles, then → READ.
- READ (1 cycle):
  - DADDR<=TBL_ADDR, DEN=1, DWE=0 → WAIT_R.
- WAIT_R:
  - DEN=0.
  - On DRDY=1: DI <= (DO & TBL_MASK) | (TBL_DATA & ~TBL_MASK) → WRITE.
- WRITE (1 cycle):
  - DEN=1, DWE=1, DADDR unchanged → WAIT_W.
- WAIT_W:
  - DEN=0, DWE=0.
  - On DRDY=1: if TBL_IDX==NUM_ENTRIES-1 → RELEASE; else TBL_IDX+1 → READ.
- RELEASE (1 cycle):
  - PLL_RST=0 → WAIT_LOCK.
- WAIT_LOCK:
  - LOCKED is sampled from the cycle after RELEASE.
  - First LOCKED=1 → DONE.
- DONE (1 cycle):
  - DONE=1, BUSY=0 → IDLE.

Timing and stability rules:
- DADDR is stable from READ through the end of WAIT_W.
- TBL_IDX is stable for a whole entry.
- DRDY seen outside WAIT_R/WAIT_W is ignored.
- DRDY in the same cycle as the DEN pulse is not accepted; DRDY is counted from the cycle after DEN.
- Exactly one DEN per READ and per WRITE; never two DEN pulses without an intervening DRDY.
- Minimum latency per entry with a 1-cycle DRDY responder: 4 cycles.
- Total minimum latency with a 1-cycle DRDY responder: START → DONE = 1 + RST_HOLD_CYCLES + 4*NUM_ENTRIES + 1 + lock time + 1.

Optional Feature:
Macro DRP_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_R, WAIT_W and WAIT_LOCK and clears on every state entry.
  - Reaching TIMEOUT_CYCLES sets ERROR=1, deasserts PLL_RST, clears BUSY and returns to IDLE.
  - DONE is not pulsed.
- Undefined:
  - No counter; the block waits indefinitely and ERROR is tied 0.

Test Plan:
1. NUM_ENTRIES=2; entry0 {7'h08, 16'hF000, 16'h0123}; entry1 {7'h09, 16'h00FF, 16'hAB00}; responder DO=16'hFFFF, 1-cycle DRDY → writes 16'hF123 @08 and 16'hABFF @09; PLL_RST high from the cycle after START until RELEASE; DONE one cycle after LOCKED rises.
2. START pulsed again while BUSY → no restart; TBL_IDX sequence 0,1 unchanged; only one DONE.
3. Responder DRDY delayed 5 cycles → single DEN per transaction; DADDR held constant; no write issued before read DRDY.
4. RST asserted during WAIT_W of entry 0 → next edge: DEN=DWE=PLL_RST=BUSY=0, TBL_IDX=0; a later START reruns the full sequence from entry 0.
5. LOCKED held 0 with DRP_TIMEOUT_EN, TIMEOUT_CYCLES=20 → ERROR=1 exactly 20 cycles into WAIT_LOCK, BUSY=0, no DONE; without the macro BUSY stays 1.
6. Responder never returns DRDY with DRP_TIMEOUT_EN → ERROR=1 in WAIT_R; next START clears ERROR and completes normally.
